// File: rtl/rx_packet_if.sv
// Byte-receiver to packet-controller to host signal bundle.
//   master: byte source and packet consumer (drives byte_*, pkt_ready)
//   slave : rx_packet_ctrl (drives pkt_*, *_err, busy)
interface rx_packet_if;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned DATA_W = 128;

  logic              byte_valid;
  logic [BYTE_W-1:0] byte_in;
  logic              byte_fe;
  logic              pkt_valid;
  logic              pkt_ready;
  logic [LEN_W-1:0]  pkt_len;
  logic [DATA_W-1:0] pkt_data;
  logic              crc_err;
  logic              fmt_err;
  logic              tmo_err;
  logic              ovr_err;
  logic              busy;

  modport master (
    output byte_valid, byte_in, byte_fe, pkt_ready,
    input  pkt_valid, pkt_len, pkt_data, crc_err, fmt_err, tmo_err, ovr_err, busy
  );

  modport slave (
    input  byte_valid, byte_in, byte_fe, pkt_ready,
    output pkt_valid, pkt_len, pkt_data, crc_err, fmt_err, tmo_err, ovr_err, busy
  );
endinterface

// File: rtl/rx_packet_ctrl.sv
// Packet-layer controller behind a UART byte receiver.
// Frames are {SYNC,L} header, L+1 payload bytes, CRC-8 (poly 0x07, init 0).
// Completed packets are held and offered to the host on a valid/ready pair.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : rx_packet_if.slave (byte strobe/data/fe in, packet + error pulses out)
// Parameters:
//   TIMEOUT : inter-byte timeout in clk cycles (1..255)
//   SYNC    : required upper nibble of the header byte
module rx_packet_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [3:0]  SYNC    = 4'hA
) (
  input logic        clk,
  input logic        rst_n,
  rx_packet_if.slave bus
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned CNT_W  = 8;
  // Counter value on the cycle before the timeout would be reached.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CRC     = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t              state;
  logic [BYTE_W-1:0]   crc;
  logic [LEN_W-1:0]    idx;
  logic [CNT_W-1:0]    tmo_cnt;
  logic [LEN_W-1:0]    pkt_len;
  logic [DATA_W-1:0]   pkt_data;
  logic                pkt_valid;
  logic                crc_err;
  logic                fmt_err;
  logic                tmo_err;
  logic                ovr_err;
  logic                busy;

  logic [BYTE_W-1:0]   crc_upd_c;
  logic                hdr_ok_c;
  logic                tmo_hit_c;

  // One byte of CRC-8, MSB first, unrolled into 8 shift/XOR stages.
  function automatic logic [BYTE_W-1:0] crc8_next(input logic [BYTE_W-1:0] crc_in,
                                                  input logic [BYTE_W-1:0] data);
    logic [BYTE_W-1:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // The header starts a fresh CRC, so seed with zero while idle.
  assign crc_upd_c = crc8_next((state == IDLE) ? 8'h00 : crc, bus.byte_in);
  assign hdr_ok_c  = !bus.byte_fe && (bus.byte_in[7:4] == SYNC);
  assign tmo_hit_c = (tmo_cnt == TMO_LAST);

  // Frame sequencer; error flags default low so each fires for one cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      crc       <= '0;
      idx       <= '0;
      tmo_cnt   <= '0;
      pkt_len   <= '0;
      pkt_data  <= '0;
      pkt_valid <= 1'b0;
      crc_err   <= 1'b0;
      fmt_err   <= 1'b0;
      tmo_err   <= 1'b0;
      ovr_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      crc_err <= 1'b0;
      fmt_err <= 1'b0;
      tmo_err <= 1'b0;
      ovr_err <= 1'b0;

      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (bus.byte_valid) begin
            if (hdr_ok_c) begin
              pkt_len  <= bus.byte_in[3:0];
              crc      <= crc_upd_c;
              pkt_data <= '0;
              idx      <= '0;
              busy     <= 1'b1;
              state    <= PAYLOAD;
            end else begin
              fmt_err <= 1'b1;
            end
          end
        end

        PAYLOAD: begin
          if (bus.byte_valid) begin
            if (bus.byte_fe) begin
              fmt_err <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              pkt_data[{idx, 3'b000} +: BYTE_W] <= bus.byte_in;
              crc     <= crc_upd_c;
              tmo_cnt <= '0;
              if (idx == pkt_len) begin
                state <= CRC;
              end else begin
                idx <= idx + 4'd1;
              end
            end
          end else if (tmo_hit_c) begin
            tmo_err <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        CRC: begin
          if (bus.byte_valid) begin
            tmo_cnt <= '0;
            if (bus.byte_fe) begin
              fmt_err <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end else if (bus.byte_in == crc) begin
              pkt_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              crc_err <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end
          end else if (tmo_hit_c) begin
            tmo_err <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        HOLD: begin
          // A byte here is lost even on the handshake edge; it is never a header.
          if (bus.byte_valid) begin
            ovr_err <= 1'b1;
          end
          if (bus.pkt_ready) begin
            pkt_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.pkt_valid = pkt_valid;
  assign bus.pkt_len   = pkt_len;
  assign bus.pkt_data  = pkt_data;
  assign bus.crc_err   = crc_err;
  assign bus.fmt_err   = fmt_err;
  assign bus.tmo_err   = tmo_err;
  assign bus.ovr_err   = ovr_err;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Bench for rx_packet_ctrl: a default-timeout instance driven from a vector
// table plus hand sequences, and a TIMEOUT=10 instance for timeout cases.
module tb_rx_packet_ctrl;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  rx_packet_if bm ();
  rx_packet_if bt ();

  rx_packet_ctrl #(.TIMEOUT(255), .SYNC(4'hA)) dut_main (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bm.slave)
  );

  rx_packet_ctrl #(.TIMEOUT(10), .SYNC(4'hA)) dut_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bt.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       bv;
    logic [7:0] b;
    logic       fe;
    logic       rdy;
    logic       ev;
    logic [3:0] el;
    logic       ecrc;
    logic       efmt;
    logic       etmo;
    logic       eovr;
    logic       ebusy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input string name, input logic bv, input logic [7:0] b,
                              input logic fe, input logic rdy, input logic ev,
                              input logic [3:0] el, input logic ecrc, input logic efmt,
                              input logic etmo, input logic eovr, input logic ebusy);
    vec_t v;
    v.name = name; v.bv = bv; v.b = b; v.fe = fe; v.rdy = rdy;
    v.ev = ev; v.el = el; v.ecrc = ecrc; v.efmt = efmt; v.etmo = etmo;
    v.eovr = eovr; v.ebusy = ebusy;
    return v;
  endfunction

  // Reference CRC-8 (poly 0x07), one input bit at a time.
  function automatic logic [7:0] crc_bits(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic bv, input logic [7:0] b, input logic fe, input logic rdy);
    bm.byte_valid = bv;
    bm.byte_in    = b;
    bm.byte_fe    = fe;
    bm.pkt_ready  = rdy;
  endtask

  task automatic drive_t(input logic bv, input logic [7:0] b, input logic fe, input logic rdy);
    bt.byte_valid = bv;
    bt.byte_in    = b;
    bt.byte_fe    = fe;
    bt.pkt_ready  = rdy;
  endtask

  function automatic logic [255:0] main_all();
    return 256'({bm.pkt_valid, bm.pkt_len, bm.pkt_data, bm.crc_err, bm.fmt_err,
                 bm.tmo_err, bm.ovr_err, bm.busy});
  endfunction

  function automatic logic [255:0] tmo_all();
    return 256'({bt.pkt_valid, bt.pkt_len, bt.pkt_data, bt.crc_err, bt.fmt_err,
                 bt.tmo_err, bt.ovr_err, bt.busy});
  endfunction

  logic [127:0] exp_data;
  logic [7:0]   c;

  initial begin
    errors = 0;
    checks = 0;

    // name, bv, byte, fe, rdy | valid, len, crc, fmt, tmo, ovr, busy
    vt.push_back(mk("t1_hdr",    1, 8'hA0, 0, 1, 0, 4'd0, 0, 0, 0, 0, 1));
    vt.push_back(mk("t1_pay",    1, 8'h00, 0, 1, 0, 4'd0, 0, 0, 0, 0, 1));
    vt.push_back(mk("t1_crc",    1, 8'h18, 0, 1, 1, 4'd0, 0, 0, 0, 0, 1));
    vt.push_back(mk("t1_xfer",   0, 8'h00, 0, 1, 0, 4'd0, 0, 0, 0, 0, 0));
    vt.push_back(mk("t1_idle",   0, 8'h00, 0, 1, 0, 4'd0, 0, 0, 0, 0, 0));
    vt.push_back(mk("bc_hdr",    1, 8'hA0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1));
    vt.push_back(mk("bc_pay",    1, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1));
    vt.push_back(mk("bc_crc",    1, 8'h19, 0, 0, 0, 4'd0, 1, 0, 0, 0, 0));
    vt.push_back(mk("bc_after",  0, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0));
    vt.push_back(mk("sync_bad",  1, 8'h50, 0, 0, 0, 4'd0, 0, 1, 0, 0, 0));
    vt.push_back(mk("sync_aft",  0, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0));
    vt.push_back(mk("fe_hdr",    1, 8'hA1, 0, 0, 0, 4'd1, 0, 0, 0, 0, 1));
    vt.push_back(mk("fe_pay",    1, 8'h11, 1, 0, 0, 4'd1, 0, 1, 0, 0, 0));
    vt.push_back(mk("fe_aft",    0, 8'h00, 0, 0, 0, 4'd1, 0, 0, 0, 0, 0));
    vt.push_back(mk("fe_sync",   1, 8'hA0, 1, 0, 0, 4'd1, 0, 1, 0, 0, 0));
    vt.push_back(mk("ov_hdr",    1, 8'hA0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1));
    vt.push_back(mk("ov_pay",    1, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1));
    vt.push_back(mk("ov_crc",    1, 8'h18, 0, 0, 1, 4'd0, 0, 0, 0, 0, 1));
    vt.push_back(mk("ov_hshk",   1, 8'hA5, 0, 1, 0, 4'd0, 0, 0, 0, 1, 0));
    vt.push_back(mk("ov_nohdr",  0, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0));
    vt.push_back(mk("fc_hdr",    1, 8'hA0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1));
    vt.push_back(mk("fc_pay",    1, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1));
    vt.push_back(mk("fc_crc",    1, 8'h18, 1, 0, 0, 4'd0, 0, 1, 0, 0, 0));
    vt.push_back(mk("fc_aft",    0, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0));

    rst_n = 1'b0;
    drive_m(0, 8'h00, 0, 0);
    drive_t(0, 8'h00, 0, 0);
    step();
    step();
    chk("reset_main", main_all(), 256'd0);
    chk("reset_tmo",  tmo_all(),  256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: inputs held across one edge, registered outputs checked after it.
    foreach (vt[i]) begin
      drive_m(vt[i].bv, vt[i].b, vt[i].fe, vt[i].rdy);
      step();
      chk(vt[i].name,
          256'({bm.pkt_valid, bm.pkt_len, bm.crc_err, bm.fmt_err, bm.tmo_err, bm.ovr_err, bm.busy}),
          256'({vt[i].ev, vt[i].el, vt[i].ecrc, vt[i].efmt, vt[i].etmo, vt[i].eovr, vt[i].ebusy}));
    end
    drive_m(0, 8'h00, 0, 0);

    // 16-byte packet, host stalls 20 cycles, one byte arrives during HOLD.
    exp_data = '0;
    c = crc_bits(8'h00, 8'hAF);
    drive_m(1, 8'hAF, 0, 0);
    step();
    for (int i = 0; i < 16; i++) begin
      drive_m(1, 8'(i), 0, 0);
      exp_data[8*i +: 8] = 8'(i);
      c = crc_bits(c, 8'(i));
      step();
    end
    drive_m(1, c, 0, 0);
    step();
    drive_m(0, 8'h00, 0, 0);
    chk("p16_first", 256'({bm.pkt_valid, bm.pkt_len, bm.pkt_data, bm.busy}),
        256'({1'b1, 4'hF, exp_data, 1'b1}));
    for (int k = 0; k < 20; k++) begin
      if (k == 7) drive_m(1, 8'h33, 0, 0);
      else        drive_m(0, 8'h00, 0, 0);
      step();
      chk($sformatf("p16_hold%0d", k), 256'({bm.pkt_valid, bm.ovr_err}),
          256'({1'b1, (k == 7)}));
    end
    chk("p16_stable", 256'({bm.pkt_len, bm.pkt_data}), 256'({4'hF, exp_data}));
    drive_m(0, 8'h00, 0, 1);
    step();
    chk("p16_taken", 256'({bm.pkt_valid, bm.busy}), 256'd0);
    drive_m(0, 8'h00, 0, 0);

    // Timeout after one payload byte of a 4-byte frame.
    drive_t(1, 8'hA3, 0, 0);
    step();
    drive_t(1, 8'h55, 0, 0);
    step();
    drive_t(0, 8'h00, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("tmo_wait%0d", k), 256'({bt.tmo_err, bt.busy}), 256'({1'b0, 1'b1}));
    end
    step();
    chk("tmo_fire", 256'({bt.tmo_err, bt.busy, bt.pkt_valid}), 256'({1'b1, 1'b0, 1'b0}));
    step();
    chk("tmo_pulse", 256'({bt.tmo_err, bt.busy}), 256'd0);

    // Good frame after the timeout.
    drive_t(1, 8'hA0, 0, 1);
    step();
    drive_t(1, 8'h00, 0, 1);
    step();
    drive_t(1, 8'h18, 0, 1);
    step();
    drive_t(0, 8'h00, 0, 1);
    chk("tmo_good", 256'({bt.pkt_valid, bt.pkt_len, bt.pkt_data, bt.tmo_err}),
        256'({1'b1, 4'h0, 128'd0, 1'b0}));
    step();
    chk("tmo_good_done", 256'({bt.pkt_valid, bt.busy}), 256'd0);

    // Byte arriving on the edge the timeout would fire wins.
    drive_t(1, 8'hA0, 0, 0);
    step();
    drive_t(0, 8'h00, 0, 0);
    for (int k = 1; k <= 9; k++) step();
    drive_t(1, 8'h00, 0, 0);
    step();
    drive_t(0, 8'h00, 0, 0);
    chk("tmo_race", 256'({bt.tmo_err, bt.busy}), 256'({1'b0, 1'b1}));
    drive_t(1, 8'h18, 0, 1);
    step();
    drive_t(0, 8'h00, 0, 1);
    chk("tmo_race_pkt", 256'({bt.pkt_valid, bt.tmo_err}), 256'({1'b1, 1'b0}));
    step();
    drive_t(0, 8'h00, 0, 0);

    // Asynchronous reset in the middle of a payload.
    drive_m(1, 8'hAF, 0, 0);
    step();
    drive_m(1, 8'h01, 0, 0);
    step();
    drive_m(1, 8'h02, 0, 0);
    step();
    drive_m(0, 8'h00, 0, 0);
    chk("rst_pre", 256'({bm.busy, bm.pkt_data[15:0]}), 256'({1'b1, 16'h0201}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", main_all(), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_m(1, 8'hA0, 0, 1);
    step();
    drive_m(1, 8'h00, 0, 1);
    step();
    drive_m(1, 8'h18, 0, 1);
    step();
    drive_m(0, 8'h00, 0, 1);
    chk("rst_next_pkt", main_all(), 256'({1'b1, 4'h0, 128'd0, 5'b00001}));
    step();
    chk("rst_next_done", main_all(), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
